// File: rtl/gpio_core_if.sv
// gpio_core_if: flat register bus between the APB slave and the GPIO core.
interface gpio_core_if;
    logic        gpio_we;
    logic [31:0] gpio_addr;
    logic [31:0] gpio_data_in;
    logic [31:0] gpio_data_out;
    logic        gpio_inta_o;
    modport master (output gpio_we, gpio_addr, gpio_data_in, input gpio_data_out, gpio_inta_o);
    modport slave  (input gpio_we, gpio_addr, gpio_data_in, output gpio_data_out, gpio_inta_o);
endinterface

// File: rtl/gpio_core.sv
// gpio_core: GPIO registers, pad drive, input synchroniser and per-pin edge interrupts.
module gpio_core #(
    parameter int GPIO_WIDTH = 32
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    gpio_core_if.slave            bus,
    input  logic [GPIO_WIDTH-1:0] ext_pad_i,
    output logic [GPIO_WIDTH-1:0] ext_pad_o,
    output logic [GPIO_WIDTH-1:0] ext_padoe_o
);
    localparam int W = GPIO_WIDTH;
    logic [W-1:0] r_out, r_oe, r_inte, r_ptrig, r_ints;
    logic [W-1:0] sync1, sync2, prev, wd, evt, clr;
    logic         ctrl, inta, unused_ok;
    logic [5:0]   off;
    assign off       = bus.gpio_addr[7:2];
    assign wd        = bus.gpio_data_in[W-1:0];
    assign unused_ok = ^{bus.gpio_addr[31:8], bus.gpio_addr[1:0], bus.gpio_data_in};
    assign evt       = (r_ptrig & sync2 & ~prev) | (~r_ptrig & ~sync2 & prev);
    assign clr       = (bus.gpio_we && off == 6'd5) ? wd : '0;
    assign ext_pad_o   = r_out;
    assign ext_padoe_o = r_oe;
    assign bus.gpio_inta_o = inta;
    always_comb
        bus.gpio_data_out = off == 6'd0 ? 32'(sync2)   :
                            off == 6'd1 ? 32'(r_out)   :
                            off == 6'd2 ? 32'(r_oe)    :
                            off == 6'd3 ? 32'(r_inte)  :
                            off == 6'd4 ? 32'(r_ptrig) :
                            off == 6'd5 ? 32'(r_ints)  :
                            off == 6'd6 ? {31'b0, ctrl} : 32'b0;
    always_ff @(posedge sys_clk) begin
        if (!sys_rst) begin
            r_out   <= '0;
            r_oe    <= '0;
            r_inte  <= '0;
            r_ptrig <= '0;
            r_ints  <= '0;
            sync1   <= '0;
            sync2   <= '0;
            prev    <= '0;
            ctrl    <= 1'b0;
            inta    <= 1'b0;
        end else begin
            sync1 <= ext_pad_i;
            sync2 <= sync1;
            prev  <= sync2;
            if (bus.gpio_we && off == 6'd1) r_out   <= wd;
            if (bus.gpio_we && off == 6'd2) r_oe    <= wd;
            if (bus.gpio_we && off == 6'd3) r_inte  <= wd;
            if (bus.gpio_we && off == 6'd4) r_ptrig <= wd;
            if (bus.gpio_we && off == 6'd6) ctrl    <= bus.gpio_data_in[0];
            // a new event wins over a same-cycle W1C on that bit
            r_ints <= (r_ints & ~clr) | (evt & r_inte);
            inta   <= ctrl & |r_ints;
        end
    end
endmodule

// File: tb/tb_gpio_core.sv
// tb_gpio_core: scoreboard bench for gpio_core register, pad and interrupt behaviour.
module tb_gpio_core;
    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b0;
    logic [31:0] pad_i = '0;
    logic [31:0] pad_o, padoe_o;
    int          n_tests = 0;
    int          n_fail = 0;

    typedef struct {
        string       tag;
        int          kind;
        logic [31:0] addr;
        logic [31:0] exp;
    } item_t;
    item_t sb[$];

    gpio_core_if bus ();

    gpio_core #(.GPIO_WIDTH(32)) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .bus        (bus.slave),
        .ext_pad_i  (pad_i),
        .ext_pad_o  (pad_o),
        .ext_padoe_o(padoe_o)
    );

    always #50 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        @(negedge sys_clk);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bus.gpio_we = 1'b1;
        bus.gpio_addr = a;
        bus.gpio_data_in = d;
        tick();
        bus.gpio_we = 1'b0;
        bus.gpio_data_in = '0;
    endtask

    task automatic exp_rd(input string tag, input logic [31:0] a, input logic [31:0] e);
        item_t it;
        it.tag = tag; it.kind = 0; it.addr = a; it.exp = e;
        sb.push_back(it);
    endtask

    // kind 1 = ext_pad_o, 2 = ext_padoe_o, 3 = gpio_inta_o
    task automatic exp_sig(input string tag, input int k, input logic [31:0] e);
        item_t it;
        it.tag = tag; it.kind = k; it.addr = '0; it.exp = e;
        sb.push_back(it);
    endtask

    task automatic drain();
        item_t it;
        logic [31:0] obs;
        while (sb.size() > 0) begin
            it = sb.pop_front();
            if (it.kind == 0) begin
                bus.gpio_addr = it.addr;
                #1;
                obs = bus.gpio_data_out;
            end else begin
                obs = it.kind == 1 ? pad_o : it.kind == 2 ? padoe_o : {31'b0, bus.gpio_inta_o};
            end
            chk(it.tag, obs, it.exp);
        end
    endtask

    task automatic exp_all_zero(input string tag);
        for (int i = 0; i < 7; i++) exp_rd($sformatf("%s_reg%0d", tag, i), 32'(i * 4), 32'h0);
        exp_sig({tag, "_pad_o"}, 1, 32'h0);
        exp_sig({tag, "_padoe"}, 2, 32'h0);
        exp_sig({tag, "_inta"}, 3, 32'h0);
    endtask

    initial begin
        bus.gpio_we = 1'b0;
        bus.gpio_addr = '0;
        bus.gpio_data_in = '0;
        @(negedge sys_clk);
        tick();
        tick();
        sys_rst = 1'b1;
        exp_all_zero("reset");
        drain();

        wr(32'h04, 32'hA5A5_5A5A);
        exp_sig("pad_o_after_wr", 1, 32'hA5A5_5A5A);
        exp_sig("padoe_still0", 2, 32'h0);
        drain();
        wr(32'h08, 32'hFFFF_0000);
        exp_sig("padoe_after_wr", 2, 32'hFFFF_0000);
        exp_rd("rd_out", 32'h04, 32'hA5A5_5A5A);
        exp_rd("rd_oe", 32'h08, 32'hFFFF_0000);
        exp_rd("rd_out_alias_hi", 32'h0000_0104, 32'hA5A5_5A5A);
        exp_rd("rd_out_alias_lo", 32'h07, 32'hA5A5_5A5A);
        drain();
        wr(32'h00, 32'h1234_5678);
        wr(32'h20, 32'hFFFF_FFFF);
        exp_rd("rd_in_ro", 32'h00, 32'h0);
        exp_rd("rd_unmapped", 32'h20, 32'h0);
        exp_rd("rd_out_kept", 32'h04, 32'hA5A5_5A5A);
        exp_sig("pad_o_kept", 1, 32'hA5A5_5A5A);
        drain();
        wr(32'h18, 32'hFFFF_FFFF);
        exp_rd("ctrl_bit0_only", 32'h18, 32'h1);
        drain();
        wr(32'h18, 32'h0);

        pad_i = 32'h0000_00F0;
        tick();
        exp_rd("sync_n", 32'h00, 32'h0);
        drain();
        tick();
        exp_rd("sync_n1", 32'h00, 32'hF0);
        drain();
        pad_i = 32'h0;
        repeat (3) tick();
        exp_rd("ints_no_inte", 32'h14, 32'h0);
        drain();

        wr(32'h0C, 32'h1);
        wr(32'h10, 32'h1);
        wr(32'h18, 32'h1);
        pad_i = 32'h1;
        tick();
        tick();
        exp_rd("rise_ints_n1", 32'h14, 32'h0);
        drain();
        tick();
        exp_rd("rise_ints_n2", 32'h14, 32'h1);
        exp_sig("rise_inta_n2", 3, 32'h0);
        drain();
        tick();
        exp_sig("rise_inta_n3", 3, 32'h1);
        drain();
        wr(32'h14, 32'h1);
        exp_rd("w1c_ints", 32'h14, 32'h0);
        exp_sig("w1c_inta_lag", 3, 32'h1);
        drain();
        tick();
        exp_sig("w1c_inta_drop", 3, 32'h0);
        drain();

        wr(32'h10, 32'h0);
        wr(32'h0C, 32'h2);
        wr(32'h18, 32'h0);
        pad_i = 32'h7;
        repeat (3) tick();
        exp_rd("fall_no_rise", 32'h14, 32'h0);
        drain();
        pad_i = 32'h5;
        repeat (3) tick();
        exp_rd("fall_ints", 32'h14, 32'h2);
        drain();
        tick();
        exp_sig("fall_masked_inta", 3, 32'h0);
        drain();
        wr(32'h18, 32'h1);
        exp_sig("ctrl_inta_lag", 3, 32'h0);
        drain();
        tick();
        exp_sig("ctrl_inta_on", 3, 32'h1);
        drain();
        pad_i = 32'h1;
        repeat (3) tick();
        exp_rd("pad2_inte0", 32'h14, 32'h2);
        drain();

        wr(32'h14, 32'hFFFF_FFFF);
        exp_rd("clear_all", 32'h14, 32'h0);
        drain();
        wr(32'h0C, 32'h3);
        wr(32'h10, 32'h1);
        pad_i = 32'h0;
        repeat (3) tick();
        exp_rd("fall_ignored_rise_mode", 32'h14, 32'h0);
        drain();
        pad_i = 32'h1;
        tick();
        tick();
        wr(32'h14, 32'h1);
        exp_rd("collision_set_wins", 32'h14, 32'h1);
        drain();
        wr(32'h14, 32'h0);
        exp_rd("w1c_zero_noop", 32'h14, 32'h1);
        drain();
        tick();
        exp_sig("collision_inta", 3, 32'h1);
        drain();

        bus.gpio_we = 1'b1;
        bus.gpio_addr = 32'h04;
        bus.gpio_data_in = 32'hDEAD_BEEF;
        sys_rst = 1'b0;
        tick();
        bus.gpio_we = 1'b0;
        exp_all_zero("midrst");
        drain();
        sys_rst = 1'b1;
        tick();
        exp_rd("post_rst_in", 32'h00, 32'h0);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/gpio_core.md
Name: gpio_core

Overview:
- Register and pad-control block for the GPIO peripheral.
- Sits directly downstream of the APB slave interface. It consumes that interface's flat register bus (gpio_we, gpio_addr, gpio_data_in, all on sys_clk/sys_rst) and returns gpio_data_out and gpio_inta_o.
- Drives output pads and output enables, synchronises input pads, and raises a per-pin edge-triggered interrupt.

Parameters:
- GPIO_WIDTH, 32, number of GPIO pins (1..32).

Ports:
- sys_clk  input  1  clock; all state updates on rising edge.
- sys_rst  input  1  synchronous, active-low reset.
- gpio_we  input  1  write strobe; one cycle per APB write.
- gpio_addr  input  32  byte address; only bits [7:2] are decoded.
- gpio_data_in  input  32  write data.
- gpio_data_out  output  32  read data; combinational from gpio_addr.
- gpio_inta_o  output  1  registered interrupt request.
- ext_pad_i  input  GPIO_WIDTH  asynchronous pad inputs.
- ext_pad_o  output  GPIO_WIDTH  pad output values (= RGPIO_OUT).
- ext_padoe_o  output  GPIO_WIDTH  pad output enables (= RGPIO_OE), 1 = drive.

Behaviour:
- Reset: when sys_rst=0 at a clock edge, every register below, both sync stages, the edge-history register and gpio_inta_o go to 0. ext_pad_o and ext_padoe_o read 0 from the next cycle. Reset overrides any write in the same cycle.
- Register map (byte offsets):
  - 0x00 RGPIO_IN, RO: synchronised pads. Writes are ignored.
  - 0x04 RGPIO_OUT, RW.
  - 0x08 RGPIO_OE, RW.
  - 0x0C RGPIO_INTE, RW: per-pin interrupt enable.
  - 0x10 RGPIO_PTRIG, RW: 1 = rising-edge trigger, 0 = falling-edge trigger.
  - 0x14 RGPIO_INTS, RW1C: interrupt status. Writing 1 clears a bit; writing 0 has no effect.
  - 0x18 RGPIO_CTRL, RW: bit0 = global interrupt enable. Bits [31:1] read 0.
- Unmapped offsets (0x1C..0xFC): read 0; writes have no effect. gpio_addr[31:8] and [1:0] are ignored.
- Width rule: register bits at or above GPIO_WIDTH read 0 and ignore writes.
- Writes take effect on the sys_clk edge where gpio_we=1. They are visible on gpio_data_out and on the pads in the following cycle.
- Reads: gpio_data_out is a pure mux of the current register value selected by gpio_addr, independent of gpio_we. There is no read side effect.
- Input path: ext_pad_i feeds a 2-flop synchroniser (sync1, then sync2). RGPIO_IN = sync2. A pad change stable before edge N is visible in RGPIO_IN after edge N+1.
- Edge detect: a prev register samples sync2 every cycle.
  - rise[i] = sync2[i] & ~prev[i].
  - fall[i] = ~sync2[i] & prev[i].
  - event[i] = RGPIO_PTRIG[i] ? rise[i] : fall[i].
  - Events are detected regardless of RGPIO_OE.
- Status update, per bit, each edge: INTS[i] <= (INTS[i] & ~clr[i]) | (event[i] & INTE[i]).
  - clr[i] = gpio_we & (offset==0x14) & gpio_data_in[i].
  - A simultaneous new event and W1C on the same bit leaves the bit SET (set wins).
- Event latency:
  - Pad edge stable before edge N.
  - INTS bit set after edge N+2.
  - gpio_inta_o asserted after edge N+3.
- gpio_inta_o <= RGPIO_CTRL[0] & |INTS, registered. It deasserts one cycle after the last INTS bit clears or CTRL[0] is cleared.
- Event filtering:
  - INTE[i]=0: events are discarded and are not remembered.
  - CTRL[0]=0: INTS still latches; only the IRQ output is masked.
- PTRIG change mid-operation: the new polarity applies from the next edge. No event is synthesised from the change itself.
- Post-reset: the synchroniser may show a 0→1 transition on pins held high. This causes no status because INTE=0 after reset.

Test Plan:
- Reset values: sys_rst=0 for 2 cycles, then 1 → reads of 0x00..0x18 all return 0 (pads held 0). ext_pad_o=0, ext_padoe_o=0, gpio_inta_o=0.
- Output path: write 0x04=0xA5A5_5A5A, then 0x08=0xFFFF_0000 → ext_pad_o=0xA5A5_5A5A and ext_padoe_o=0xFFFF_0000 from the cycle after each write. Read-back matches. Write to 0x00 and 0x20 → no change; both read as before or 0.
- Input sync: ext_pad_i changes 0→0x0000_00F0 before edge N → RGPIO_IN reads 0 after edge N and 0xF0 after edge N+1.
- Rising-edge IRQ: INTE=0x1, PTRIG=0x1, CTRL=0x1, pad0 0→1 before edge N → INTS=0x1 after edge N+2 and gpio_inta_o=1 after edge N+3. Write 0x14=0x1 → INTS=0, and gpio_inta_o=0 one cycle later.
- Falling edge and masking: PTRIG=0, INTE=0x2, CTRL=0.
  - pad1 1→0 → INTS=0x2, gpio_inta_o stays 0.
  - Set CTRL=1 → gpio_inta_o=1 next cycle.
  - pad2 falling with INTE[2]=0 → INTS unchanged.
- Collision and reset: W1C of bit0 on the same edge a new bit0 event is latched → INTS bit0 remains 1. Assert sys_rst=0 mid-sequence → all registers and gpio_inta_o are 0 after that edge.
